fetch_queue: RTL and testbench

// - Prefetching instruction fetch unit: streams sequential instructions from a 1-cycle-latency synchronous

---
 rtl/fetch_queue.sv | 101 ++++++++++
 tb/tb_fetch_queue.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// fetch_queue: prefetching instruction fetch unit.
// It streams sequential instructions from a synchronous instruction memory with 1-cycle latency
// into a DEPTH-entry FIFO and hands them to decode over a valid/ready handshake.
// The fetch issue rate is limited by a credit check: queue occupancy plus the in-flight request.
// A redirect flushes the queue, squashes any in-flight response and restarts fetch at a new PC.
module fetch_queue #(
  parameter int                ADDR_W   = 12,
  parameter int                INSTR_W  = 16,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       reset_n,
  output logic                       imem_req,
  output logic [ADDR_W-1:0]          imem_addr,
  input  logic [INSTR_W-1:0]         imem_rdata,
  input  logic                       redirect,
  input  logic [ADDR_W-1:0]          redirect_pc,
  output logic                       instr_valid,
  input  logic                       instr_ready,
  output logic [INSTR_W-1:0]         instr,
  output logic [ADDR_W-1:0]          instr_pc,
  output logic [$clog2(DEPTH+1)-1:0] fq_count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [ADDR_W-1:0]  fetch_pc;
  logic [ADDR_W-1:0]  inflight_pc;
  logic               inflight;
  logic [PW-1:0]      head;
  logic [PW-1:0]      tail;
  logic [CW-1:0]      count;
  logic [CW:0]        occupancy;
  logic               push;
  logic               pop;

  logic [INSTR_W-1:0] q_instr [DEPTH];
  logic [ADDR_W-1:0]  q_pc    [DEPTH];

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // A pop in the same cycle is deliberately not counted as credit. This keeps imem_req off the
  // consumer's ready path.
  assign occupancy = {1'b0, count} + (CW+1)'(inflight);
  assign imem_req  = reset_n & ~redirect & (occupancy < (CW+1)'(DEPTH));
  assign imem_addr = fetch_pc;

  // A redirect squashes the response arriving this cycle and blocks the pop.
  assign push = inflight & ~redirect;
  assign pop  = (count != '0) & instr_ready & ~redirect;

  assign instr_valid = (count != '0);
  assign fq_count    = count;
  // The head is gated so that the outputs read zero whenever the queue is empty.
  assign instr       = instr_valid ? q_instr[head] : '0;
  assign instr_pc    = instr_valid ? q_pc[head]    : '0;

  // Fetch PC, in-flight tracking, queue pointers and occupancy.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      head        <= '0;
      tail        <= '0;
      count       <= '0;
    end else if (redirect) begin
      fetch_pc <= redirect_pc;
      inflight <= 1'b0;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
    end else begin
      inflight <= imem_req;
      if (imem_req) begin
        inflight_pc <= fetch_pc;
        fetch_pc    <= fetch_pc + 1'b1;
      end
      if (push) tail <= ptr_next(tail);
      if (pop)  head <= ptr_next(head);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Queue storage. Occupancy and the output gating make a reset of the storage unnecessary.
  always_ff @(posedge clk) begin
    if (push) begin
      q_instr[tail] <= imem_rdata;
      q_pc[tail]    <= inflight_pc;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed self-checking bench for fetch_queue.
// Memory model: mem[a] = a + 16'hA000, with 1-cycle read latency.
module tb_fetch_queue;

  localparam int ADDR_W  = 12;
  localparam int INSTR_W = 16;
  localparam int DEPTH   = 4;
  localparam int CW      = $clog2(DEPTH + 1);

  logic               clk;
  logic               reset_n;
  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic               redirect;
  logic [ADDR_W-1:0]  redirect_pc;
  logic               instr_valid;
  logic               instr_ready;
  logic [INSTR_W-1:0] instr;
  logic [ADDR_W-1:0]  instr_pc;
  logic [CW-1:0]      fq_count;

  int total  = 0;
  int passed = 0;
  int failed = 0;

  fetch_queue #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .DEPTH(DEPTH), .RESET_PC('0)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .fq_count    (fq_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous instruction memory
  always_ff @(posedge clk) begin
    if (imem_req) imem_rdata <= {4'b0000, imem_addr} + 16'hA000;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_head(input string tag, input logic [ADDR_W-1:0] pc);
    logic [INSTR_W-1:0] e;
    e = {4'b0000, pc} + 16'hA000;
    chk({tag, "_valid"}, 32'(instr_valid), 32'd1);
    chk({tag, "_pc"},    32'(instr_pc),    32'(pc));
    chk({tag, "_instr"}, 32'(instr),       32'(e));
  endtask

  // Move to 1 time unit after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Hold reset across two edges and release it 1 time unit after an edge.
  // On return the bench is in cycle 0, with 2 time units elapsed since that edge.
  task automatic do_reset(input logic rdy);
    reset_n     = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    instr_ready = rdy;
    @(posedge clk);
    @(posedge clk);
    #1 reset_n = 1'b1;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // ---- Streaming with ready=1 ----
    do_reset(1'b1);
    chk("c0_req",   32'(imem_req),    32'd1);
    chk("c0_addr",  32'(imem_addr),   32'h000);
    chk("c0_valid", 32'(instr_valid), 32'd0);
    chk("c0_count", 32'(fq_count),    32'd0);
    cyc(); #1;
    chk("c1_valid", 32'(instr_valid), 32'd0);
    chk("c1_addr",  32'(imem_addr),   32'h001);
    cyc(); #1;
    chk_head("c2", 12'h000);
    chk("c2_count", 32'(fq_count),  32'd1);
    chk("c2_addr",  32'(imem_addr), 32'h002);
    for (int k = 1; k < 6; k++) begin
      cyc(); #1;
      chk_head("stream", 12'(k));
      chk("stream_count", 32'(fq_count), 32'd1);
    end

    // ---- Asynchronous reset mid-stream ----
    #1 reset_n = 1'b0;
    #1;
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_count", 32'(fq_count),    32'd0);
    chk("rst_instr", 32'(instr),       32'd0);
    chk("rst_pc",    32'(instr_pc),    32'd0);
    chk("rst_req",   32'(imem_req),    32'd0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    #1;
    chk("rr_req",  32'(imem_req),  32'd1);
    chk("rr_addr", 32'(imem_addr), 32'h000);
    cyc(); #1;
    chk("rr_c1_valid", 32'(instr_valid), 32'd0);
    cyc(); #1;
    chk_head("rr_c2", 12'h000);

    // ---- Back-pressure fill and drain ----
    do_reset(1'b0);
    for (int k = 0; k < 4; k++) cyc();
    #1;
    chk("bp_c4_count", 32'(fq_count), 32'd3);
    chk("bp_c4_req",   32'(imem_req), 32'd0);
    cyc(); #1;
    chk("bp_c5_count", 32'(fq_count), 32'd4);
    chk("bp_c5_req",   32'(imem_req), 32'd0);
    chk_head("bp_c5", 12'h000);
    cyc(); #1;
    chk_head("bp_c6_hold", 12'h000);
    instr_ready = 1'b1;
    #0.5;
    chk("bp_c6_req_popnocredit", 32'(imem_req), 32'd0);
    cyc(); #1;
    chk_head("bp_drain1", 12'h001);
    chk("bp_c7_req",  32'(imem_req),  32'd1);
    chk("bp_c7_addr", 32'(imem_addr), 32'h004);
    for (int k = 2; k < 6; k++) begin
      cyc(); #1;
      chk_head("bp_drain", 12'(k));
    end

    // ---- Redirect with 3 entries queued plus 1 in flight ----
    do_reset(1'b0);
    for (int k = 0; k < 4; k++) cyc();
    #1;
    chk("rd_c4_count", 32'(fq_count), 32'd3);
    redirect    = 1'b1;
    redirect_pc = 12'h100;
    #0.5;
    chk("rd_c4_req", 32'(imem_req), 32'd0);
    cyc();
    redirect    = 1'b0;
    instr_ready = 1'b1;
    #1;
    chk("rd_c5_count", 32'(fq_count),    32'd0);
    chk("rd_c5_valid", 32'(instr_valid), 32'd0);
    chk("rd_c5_req",   32'(imem_req),    32'd1);
    chk("rd_c5_addr",  32'(imem_addr),   32'h100);
    cyc(); #1;
    chk("rd_c6_count", 32'(fq_count),    32'd0);
    chk("rd_c6_valid", 32'(instr_valid), 32'd0);
    cyc(); #1;
    chk_head("rd_first", 12'h100);
    cyc(); #1;
    chk_head("rd_second", 12'h101);

    // ---- Simultaneous pop and write, then redirect coincident with a pop ----
    do_reset(1'b0);
    for (int k = 0; k < 3; k++) cyc();
    #1;
    chk("pw_c3_count", 32'(fq_count), 32'd2);
    instr_ready = 1'b1;
    #0.5;
    chk_head("pw_c3", 12'h000);
    cyc(); #1;
    chk("pw_c4_count", 32'(fq_count), 32'd2);
    chk_head("pw_c4", 12'h001);
    cyc(); #1;
    chk("pw_c5_count", 32'(fq_count), 32'd2);
    chk_head("pw_c5", 12'h002);
    redirect    = 1'b1;
    redirect_pc = 12'h040;
    #0.5;
    chk("rp_req_blocked", 32'(imem_req), 32'd0);
    cyc();
    redirect = 1'b0;
    #1;
    chk("rp_count", 32'(fq_count),    32'd0);
    chk("rp_valid", 32'(instr_valid), 32'd0);
    chk("rp_addr",  32'(imem_addr),   32'h040);
    cyc(); cyc(); #1;
    chk_head("rp_first", 12'h040);

    // ---- Back-to-back redirects, where the last one wins, then the PC wraps ----
    do_reset(1'b1);
    for (int k = 0; k < 3; k++) cyc();
    redirect    = 1'b1;
    redirect_pc = 12'h200;
    cyc();
    redirect_pc = 12'hFFE;
    cyc();
    redirect = 1'b0;
    #1;
    chk("wr_req",   32'(imem_req),    32'd1);
    chk("wr_addr0", 32'(imem_addr),   32'hFFE);
    chk("wr_count", 32'(fq_count),    32'd0);
    cyc(); #1;
    chk("wr_addr1", 32'(imem_addr),   32'hFFF);
    chk("wr_valid", 32'(instr_valid), 32'd0);
    cyc(); #1;
    chk_head("wrap0", 12'hFFE);
    cyc(); #1;
    chk_head("wrap1", 12'hFFF);
    cyc(); #1;
    chk_head("wrap2", 12'h000);
    cyc(); #1;
    chk_head("wrap3", 12'h001);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
